banked_lane_bram: RTL and testbench
===================================

Name: banked_lane_bram

Overview:
- Parametrised successor to the fixed 16x32-bit banked feature-map buffer.
- LANES independent single-clock memory lanes of LANE_W bits x DEPTH words.
  - One shared write address with a per-lane write mask.
  - A separate read address per lane.
- Adds a configurable read latency with an aligned valid strobe, write-first bypass on same-address collisions, and a hardware clear sequencer that zeroes the whole array.
- Sits between the DMA write path and the PE-array operand fetch.

Parameters:
- LANES, 16, number of independent memory lanes.
- LANE_W, 32, data width per lane in bits.
- DEPTH, 512, words per lane; need not be a power of two.
- AW, $clog2(DEPTH), address width per lane.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2; 2 adds an output register stage.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous active-low reset.
- clr_start  in  1  one-cycle pulse that starts the zero-fill of all lanes; ignored while clr_busy=1.
- clr_busy  out  1  high while the clear sequencer runs.
- wr_en  in  1  write strobe.
- wr_mask  in  LANES  lane i is written only when wr_en=1 and wr_mask[i]=1.
- wr_addr  in  AW  shared write address.
- wr_data  in  LANES*LANE_W  lane i data in bits [i*LANE_W +: LANE_W].
- rd_en  in  1  read strobe, applies to all lanes.
- rd_addr  in  LANES*AW  lane i address in bits [i*AW +: AW].
- rd_data  out  LANES*LANE_W  read data, lane-packed the same way as wr_data.
- rd_valid  out  1  rd_data is valid for the read issued RD_LAT cycles earlier.
- addr_err  out  1  sticky flag: a write or read address >= DEPTH was seen; cleared by reset or clr_start.

Behaviour:
- Reset (async assert, sync release):
  - rd_data=0, rd_valid=0, clr_busy=0, addr_err=0; FSM goes to IDLE.
  - Memory contents are not reset; only the clear sequence zeroes them.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clr_start. The clear counter loads 0 and addr_err clears in that same cycle.
  - CLEAR:
    - Writes zero to all lanes at the counter address each cycle, then increments the counter.
    - Moves to IDLE in the cycle after the DEPTH-1 write. Total busy time is exactly DEPTH cycles.
    - clr_busy=1 throughout CLEAR, registered.
  - A clr_start pulse while in CLEAR is ignored.
- Access during CLEAR:
  - wr_en and rd_en are ignored (no memory update, no rd_valid).
  - addr_err is not updated.
- Write:
  - When wr_en=1 and wr_addr<DEPTH, each masked lane stores its slice at the rising edge.
  - wr_mask=0 is legal and does nothing.
- Read:
  - When rd_en=1, lane i samples mem_i[rd_addr_i].
  - RD_LAT=1: rd_data and rd_valid update at the next edge.
  - RD_LAT=2: one further register stage is added to both.
  - rd_valid is a pure pipeline of rd_en (gated by IDLE). Back-to-back reads give one result per cycle, in order.
  - rd_data holds its last value while rd_valid=0.
- Collision (write-first, per lane, same cycle): wr_en=1, wr_mask[i]=1 and wr_addr==rd_addr_i.
  - Lane i returns the new wr_data slice.
  - Unmasked lanes return the old contents.
- Out of range (address >= DEPTH; only possible when DEPTH is not a power of two):
  - A write is dropped and sets addr_err.
  - A read returns 0 on that lane, still asserts rd_valid, and sets addr_err.
- Reset asserted mid-CLEAR: the FSM aborts to IDLE, clr_busy=0, and the partially cleared contents are left unspecified. The pipeline valids are flushed.
- Storage is a behavioural array per lane inferring simple dual-port block RAM. No vendor IP instances.

Test Plan:
- Defaults; write lane i = 32'h1000_0000+i at addr 5 with wr_mask=16'hFFFF; read all lanes at addr 5 -> after 1 cycle rd_valid=1 and lane i = 32'h1000_0000+i.
- Per-lane addressing: write addr a = {lane, a} for a=0..511; issue one read with rd_addr_i = 511-i -> lane i returns {i, 511-i}; repeat with RD_LAT=2 -> same data, 2-cycle latency, back-to-back reads streamed with no gaps.
- Collision: mem[7]=32'hAAAA_AAAA; same cycle write 32'h5555_5555 to addr 7 with wr_mask=16'h0001 and read all lanes at 7 -> lane 0 = 32'h5555_5555, lanes 1..15 = 32'hAAAA_AAAA.
- Clear: fill all memory with ones, pulse clr_start -> clr_busy high exactly 512 cycles; a write during clear is ignored; afterwards a read of every address returns 0.
- DEPTH=300: write addr 300 -> addr_err=1 and no memory change; read addr 310 -> lane data 0 with rd_valid=1; then clr_start -> addr_err=0.
- Assert rst_n low at clear cycle 100 with a read in flight -> clr_busy=0, rd_valid=0, rd_data=0 immediately (asynchronous).

Source files
------------

// File: rtl/banked_lane_bram.sv
// LANES independent simple-dual-port memory lanes with a shared write address, per-lane read
// addresses, selectable read latency, write-first bypass and a zero-fill clear sequencer.
module banked_lane_bram #(
    parameter int unsigned LANES  = 16,
    parameter int unsigned LANE_W = 32,
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned AW     = $clog2(DEPTH),
    parameter int unsigned RD_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr_start,
    output logic                      clr_busy,
    input  logic                      wr_en,
    input  logic [LANES-1:0]          wr_mask,
    input  logic [AW-1:0]             wr_addr,
    input  logic [LANES*LANE_W-1:0]   wr_data,
    input  logic                      rd_en,
    input  logic [LANES*AW-1:0]       rd_addr,
    output logic [LANES*LANE_W-1:0]   rd_data,
    output logic                      rd_valid,
    output logic                      addr_err
);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic              addr_err_q, addr_err_d;

    logic              idle, clearing;
    logic              wr_addr_oob;
    logic [LANES-1:0]  rd_addr_oob;
    logic              rd_fire;

    logic [LANES*LANE_W-1:0] rd_word;
    logic [LANES*LANE_W-1:0] rd1_q;
    logic                    v1_q;

    assign idle        = (state_q == StIdle);
    assign clearing    = (state_q == StClear);
    assign wr_addr_oob = ({1'b0, wr_addr} >= DEPTH_EXT);
    assign rd_fire     = idle && rd_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_err_q <= addr_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_err_d = addr_err_q;
        unique case (state_q)
            StIdle: begin
                if (clr_start) begin
                    state_d    = StClear;
                    cnt_d      = '0;
                    addr_err_d = 1'b0;
                end else if ((wr_en && wr_addr_oob) || (rd_en && |rd_addr_oob)) begin
                    addr_err_d = 1'b1;
                end
            end
            StClear: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [LANE_W-1:0] mem [DEPTH];
        logic [AW-1:0]     ra;
        logic [LANE_W-1:0] wd;
        logic              we;
        logic              hit;

        assign ra             = rd_addr[i*AW +: AW];
        assign wd             = wr_data[i*LANE_W +: LANE_W];
        assign rd_addr_oob[i] = ({1'b0, ra} >= DEPTH_EXT);
        assign we             = clearing || (idle && wr_en && wr_mask[i] && !wr_addr_oob);
        // Write-first: a same-cycle write to the read address forwards the new data.
        assign hit            = wr_en && wr_mask[i] && (wr_addr == ra);

        always_ff @(posedge clk) begin
            if (we) mem[clearing ? cnt_q : wr_addr] <= clearing ? '0 : wd;
        end

        assign rd_word[i*LANE_W +: LANE_W] = rd_addr_oob[i] ? '0 : (hit ? wd : mem[ra]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1_q <= '0;
            v1_q  <= 1'b0;
        end else begin
            v1_q <= rd_fire;
            if (rd_fire) rd1_q <= rd_word;
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [LANES*LANE_W-1:0] rd2_q;
        logic                    v2_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd2_q <= '0;
                v2_q  <= 1'b0;
            end else begin
                v2_q <= v1_q;
                if (v1_q) rd2_q <= rd1_q;
            end
        end

        assign rd_data  = rd2_q;
        assign rd_valid = v2_q;
    end else begin : g_lat1
        assign rd_data  = rd1_q;
        assign rd_valid = v1_q;
    end

    assign clr_busy = clearing;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_banked_lane_bram.sv
// Directed bench: three instances (RD_LAT=1, RD_LAT=2, DEPTH=300) checked against
// hand-computed expectations.
module tb_banked_lane_bram;

    localparam int L  = 16;
    localparam int W  = 32;
    localparam int A  = 9;

    logic               clk, rst_n;
    logic               clr_start, clr_start_b;
    logic               wr_en, wr_en_b, rd_en, rd_en_b;
    logic [L-1:0]       wr_mask;
    logic [A-1:0]       wr_addr;
    logic [L*W-1:0]     wr_data;
    logic [L*A-1:0]     rd_addr;

    logic [L*W-1:0]     rd_data0, rd_data1, rd_data2;
    logic               rd_valid0, rd_valid1, rd_valid2;
    logic               clr_busy0, clr_busy1, clr_busy2;
    logic               addr_err0, addr_err1, addr_err2;

    int checks   = 0;
    int failures = 0;

    banked_lane_bram #(.LANES(L), .LANE_W(W), .DEPTH(512), .RD_LAT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clr_start(clr_start), .clr_busy(clr_busy0),
        .wr_en(wr_en), .wr_mask(wr_mask), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0),
        .addr_err(addr_err0)
    );

    banked_lane_bram #(.LANES(L), .LANE_W(W), .DEPTH(512), .RD_LAT(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clr_start(clr_start), .clr_busy(clr_busy1),
        .wr_en(wr_en), .wr_mask(wr_mask), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1),
        .addr_err(addr_err1)
    );

    banked_lane_bram #(.LANES(L), .LANE_W(W), .DEPTH(300), .RD_LAT(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .clr_start(clr_start_b), .clr_busy(clr_busy2),
        .wr_en(wr_en_b), .wr_mask(wr_mask), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en_b), .rd_addr(rd_addr), .rd_data(rd_data2), .rd_valid(rd_valid2),
        .addr_err(addr_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [L*W-1:0] got, input logic [L*W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd_all(input int a);
        for (int i = 0; i < L; i++) rd_addr[i*A +: A] = A'(a);
    endtask

    task automatic set_wd_all(input logic [W-1:0] d);
        for (int i = 0; i < L; i++) wr_data[i*W +: W] = d;
    endtask

    function automatic logic [W-1:0] fill_word(input int i, input int a);
        return {16'(i), 16'(a)};
    endfunction

    function automatic int pat_addr(input int k, input int i);
        return (k * 37 + i * 5) % 512;
    endfunction

    function automatic logic [L*W-1:0] pat_exp(input int k);
        logic [L*W-1:0] e;
        for (int i = 0; i < L; i++) e[i*W +: W] = fill_word(i, pat_addr(k, i));
        return e;
    endfunction

    initial begin
        logic [L*W-1:0] e;
        logic [L*W-1:0] acc;
        logic           vall, saw;
        int             n;

        rst_n = 1'b0; clr_start = 1'b0; clr_start_b = 1'b0;
        wr_en = 1'b0; wr_en_b = 1'b0; rd_en = 1'b0; rd_en_b = 1'b0;
        wr_mask = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        repeat (3) tick();
        check("rst_rd_data", rd_data0, '0);
        check("rst_rd_valid", rd_valid0, 1'b0);
        check("rst_clr_busy", clr_busy0, 1'b0);
        check("rst_addr_err", addr_err0, 1'b0);
        check("rst_rd_data_lat2", rd_data1, '0);
        check("rst_addr_err_d300", addr_err2, 1'b0);
        rst_n = 1'b1;
        tick();

        // Basic write then read at address 5
        wr_en = 1'b1; wr_mask = 16'hFFFF; wr_addr = 9'd5;
        for (int i = 0; i < L; i++) wr_data[i*W +: W] = 32'h1000_0000 + 32'(i);
        e = wr_data;
        tick();
        wr_en = 1'b0; set_rd_all(5); rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("basic_valid", rd_valid0, 1'b1);
        check("basic_data", rd_data0, e);
        check("basic_lat2_pending", rd_valid1, 1'b0);
        tick();
        check("basic_lat2_valid", rd_valid1, 1'b1);
        check("basic_lat2_data", rd_data1, e);
        check("basic_valid_drop", rd_valid0, 1'b0);

        // Fill every address with {lane, addr}
        wr_mask = 16'hFFFF; wr_en = 1'b1;
        for (int a = 0; a < 512; a++) begin
            wr_addr = A'(a);
            for (int i = 0; i < L; i++) wr_data[i*W +: W] = fill_word(i, a);
            tick();
        end
        wr_en = 1'b0;
        for (int i = 0; i < L; i++) begin
            rd_addr[i*A +: A] = A'(511 - i);
            e[i*W +: W] = fill_word(i, 511 - i);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("lane_addr_valid", rd_valid0, 1'b1);
        check("lane_addr_data", rd_data0, e);
        tick();
        check("lane_addr_hold_valid", rd_valid0, 1'b0);
        check("lane_addr_hold_data", rd_data0, e);
        check("lane_addr_lat2_valid", rd_valid1, 1'b1);
        check("lane_addr_lat2_data", rd_data1, e);

        // Back-to-back stream of four reads
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                for (int i = 0; i < L; i++) rd_addr[i*A +: A] = A'(pat_addr(k, i));
                rd_en = 1'b1;
            end else begin
                rd_en = 1'b0;
            end
            tick();
            check($sformatf("stream_lat1_valid_%0d", k), rd_valid0, (k < 4) ? 1'b1 : 1'b0);
            if (k < 4) check($sformatf("stream_lat1_data_%0d", k), rd_data0, pat_exp(k));
            check($sformatf("stream_lat2_valid_%0d", k), rd_valid1,
                  (k >= 1 && k <= 4) ? 1'b1 : 1'b0);
            if (k >= 1 && k <= 4)
                check($sformatf("stream_lat2_data_%0d", k), rd_data1, pat_exp(k - 1));
        end

        // Write-first collision on lane 0 only
        wr_addr = 9'd7; wr_mask = 16'hFFFF; set_wd_all(32'hAAAA_AAAA); wr_en = 1'b1;
        tick();
        wr_mask = 16'h0001; set_wd_all(32'h5555_5555); set_rd_all(7); rd_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        for (int i = 0; i < L; i++) e[i*W +: W] = (i == 0) ? 32'h5555_5555 : 32'hAAAA_AAAA;
        check("collision_lat1", rd_data0, e);
        tick();
        check("collision_lat2", rd_data1, e);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("collision_stored", rd_data0, e);

        // Fill ones, then clear
        wr_mask = 16'hFFFF; set_wd_all('1); wr_en = 1'b1;
        for (int a = 0; a < 512; a++) begin
            wr_addr = A'(a);
            tick();
        end
        wr_en = 1'b0; clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        wr_en = 1'b1; wr_addr = 9'd3; set_rd_all(3); rd_en = 1'b1;
        n = 0; saw = 1'b0;
        while (clr_busy0 && n < 1000) begin
            n++;
            if (rd_valid0 || rd_valid1) saw = 1'b1;
            tick();
        end
        wr_en = 1'b0; rd_en = 1'b0;
        check("clr_busy_cycles", n, 512);
        check("clr_no_rd_valid", saw, 1'b0);
        acc = '0; vall = 1'b1;
        for (int a = 0; a < 512; a++) begin
            set_rd_all(a); rd_en = 1'b1;
            tick();
            acc  = acc | rd_data0;
            vall = vall & rd_valid0;
        end
        rd_en = 1'b0;
        check("clr_all_zero", acc, '0);
        check("clr_rd_valid_all", vall, 1'b1);
        check("no_addr_err_d512", addr_err0, 1'b0);

        // DEPTH=300 instance: out-of-range accesses
        wr_en_b = 1'b1; wr_addr = 9'd44;
        for (int i = 0; i < L; i++) wr_data[i*W +: W] = 32'hCAFE_0000 + 32'(i);
        e = wr_data;
        tick();
        check("oob_err_clean", addr_err2, 1'b0);
        wr_addr = 9'd300; set_wd_all('1);
        tick();
        wr_en_b = 1'b0;
        check("oob_wr_err", addr_err2, 1'b1);
        set_rd_all(44); rd_en_b = 1'b1;
        tick();
        rd_en_b = 1'b0;
        check("oob_wr_dropped_valid", rd_valid2, 1'b1);
        check("oob_wr_dropped_data", rd_data2, e);
        clr_start_b = 1'b1;
        tick();
        clr_start_b = 1'b0;
        check("oob_clr_err", addr_err2, 1'b0);
        check("oob_clr_busy", clr_busy2, 1'b1);
        n = 0;
        while (clr_busy2 && n < 1000) begin
            n++;
            tick();
        end
        check("oob_clr_cycles", n, 300);
        set_rd_all(310); rd_en_b = 1'b1;
        tick();
        rd_en_b = 1'b0;
        check("oob_rd_valid", rd_valid2, 1'b1);
        check("oob_rd_data", rd_data2, '0);
        check("oob_rd_err", addr_err2, 1'b1);

        // Async reset in the middle of a clear
        wr_addr = 9'd9; set_wd_all(32'h0BAD_F00D); wr_en = 1'b1;
        tick();
        wr_en = 1'b0; set_rd_all(9); rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        set_wd_all(32'h0BAD_F00D);
        check("pre_rst_data", rd_data0, wr_data);
        tick();
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0; rd_en = 1'b1;
        repeat (100) tick();
        check("mid_clr_busy", clr_busy0, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_busy", clr_busy0, 1'b0);
        check("async_rst_valid", rd_valid0, 1'b0);
        check("async_rst_data", rd_data0, '0);
        check("async_rst_data_lat2", rd_data1, '0);
        check("async_rst_busy_lat2", clr_busy1, 1'b0);
        check("async_rst_err_d300", addr_err2, 1'b0);
        rd_en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", clr_busy0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
